vex_uop_sequencer: RTL and testbench
====================================

Name: vex_uop_sequencer

Overview:
- Issue-side initiator for the vector execution lanes.
- Accepts one decoded vector arithmetic instruction at a time and splits it into micro-ops (uops) of VECTOR_LANES elements each.
- Drives per-lane valid and mask, honours the lanes' ready backpressure, and generates the head/end-uop markers aligned to EX3 plus the end-of-instruction done pulse that the lanes consume.
- Sits between the vector decode/operand-read stage and the array of lane pipes.

Parameters:
- VECTOR_LANES, 8, number of lanes (elements per uop); power of two, 2..16.
- VL_W, 7, width of the vl field.
- VLMAX, 64, maximum legal vl; larger values saturate to VLMAX.
- EX_DEPTH, 3, cycles from issue fire to the EX3 marker outputs.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid_i  in  1  instruction offered
- instr_ready_o  out  1  sequencer idle, instruction accepted when valid&ready
- funct6_i  in  6  operation
- funct3_i  in  3  operand category
- vl_i  in  VL_W  vector length
- vm_i  in  1  1 = unmasked
- v0_i  in  VLMAX  mask register v0
- is_rdc_i  in  1  reduction instruction
- lane_ready_i  in  VECTOR_LANES  per-lane ready
- lane_valid_o  out  VECTOR_LANES  per-lane element valid
- lane_mask_o  out  VECTOR_LANES  per-lane element mask
- funct6_o  out  6  latched funct6
- funct3_o  out  3  latched funct3
- is_rdc_o  out  1  latched is_rdc
- vl_o  out  VL_W  latched, saturated vl
- uop_idx_o  out  $clog2(VLMAX/VECTOR_LANES)  current uop index
- head_uop_ex3_o  out  1  first uop at EX3
- end_uop_ex3_o  out  1  last uop at EX3
- done_o  out  1  one-cycle end-of-instruction pulse
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values:
  - State IDLE; instr_ready_o=1; busy_o=0.
  - lane_valid_o, lane_mask_o, markers, done_o, uop_idx_o, all latched fields = 0.
  - The marker shift register is cleared.
- Reset mid-operation aborts the instruction: no done_o, no further markers.
- IDLE:
  - instr_ready_o=1.
  - On instr_valid_i, latch funct6, funct3, is_rdc, vm, v0, and vl_sat = min(vl_i, VLMAX).
  - Compute num_uops = ceil(vl_sat/VECTOR_LANES) and go to ISSUE.
  - vl_sat==0 goes directly to DRAIN with no uop issued.
- ISSUE:
  - Element index e(k) = uop_idx*VECTOR_LANES + k.
  - lane_valid_o[k] = (e(k) < vl_sat).
  - lane_mask_o[k] = vm | v0[e(k)], gated by lane_valid_o[k].
  - fire = &lane_ready_i. All lanes advance together; there is no partial issue.
  - Without fire, every lane output holds stable.
  - On fire: push marker {head = (uop_idx==0), end = (uop_idx==num_uops-1)} into the EX_DEPTH-deep shift register and increment uop_idx.
  - On fire of the last uop, go to DRAIN; lane_valid_o drops to 0 in the next cycle.
  - Single-uop instruction: the pushed marker has head=end=1.
- Marker pipe:
  - Shift register advances every cycle, independent of backpressure; lanes are not stalled after issue.
  - head_uop_ex3_o and end_uop_ex3_o are its last stage, so they assert exactly EX_DEPTH cycles after the corresponding fire.
  - Non-fire cycles push zeros.
- DRAIN:
  - Wait until the shift register is empty, i.e. the end marker has been presented.
  - In the cycle after end_uop_ex3_o, assert done_o for 1 cycle and return to IDLE.
  - vl_sat==0 case: done_o asserts 1 cycle after acceptance.
- Throughput: a new instruction can be accepted in the cycle after done_o. Instructions do not overlap.
- vl not a multiple of VECTOR_LANES: the last uop has the upper lanes' lane_valid_o=0.
- funct6_o, funct3_o, is_rdc_o and vl_o stay valid from acceptance until done_o.

Decomposition:
- Shared package: sequencer state enum (IDLE, ISSUE, DRAIN) and the marker struct {head, end}.
- The existing funct3/funct6 constants are reused unchanged.
- One sub-module is natural: vex_marker_pipe, a parameterised EX_DEPTH-deep shift register with an empty flag.

Test Plan (default parameters):
1. vl=20, vm=1, all lanes ready -> 3 fires on consecutive cycles.
   - Lane_valid patterns 0xFF, 0xFF, 0x0F.
   - head_uop_ex3_o 3 cycles after the first fire, end_uop_ex3_o 3 cycles after the third.
   - done_o 1 cycle later.
2. vl=8 -> single uop; head_uop_ex3_o and end_uop_ex3_o high in the same cycle; done_o the following cycle.
3. vl=16, vm=0, v0=0x0000_00A5_0000_3C0F -> lane_mask_o = 0x0F then 0x3C.
4. vl=24, lane_ready_i[3]=0 for 4 cycles during uop 1 -> outputs frozen and uop_idx_o=1 held during the stall; no marker pushed; markers are later spaced by the stall.
5. vl=0 -> no lane_valid; done_o 1 cycle after acceptance. vl=100 -> vl_o=64, 8 uops.
6. rst_n asserted during uop 2 of vl=64 -> all outputs at reset values immediately; no done_o; the next instruction runs normally.

Source files
------------

// File: rtl/vex_uop_sequencer_pkg.sv
// Shared types for the vector uop sequencer: sequencer states, the EX3 marker
// record and the vector funct3/funct6 encodings used by decode.
package vex_uop_sequencer_pkg;

  typedef logic [1:0] seq_state_t;
  localparam seq_state_t ST_IDLE  = 2'd0;
  localparam seq_state_t ST_ISSUE = 2'd1;
  localparam seq_state_t ST_DRAIN = 2'd2;

  // "last" carries the end-of-instruction marker (end is a keyword)
  typedef struct packed {
    logic head;
    logic last;
  } marker_t;

  localparam logic [2:0] FUNCT3_OPIVV = 3'b000;
  localparam logic [2:0] FUNCT3_OPFVV = 3'b001;
  localparam logic [2:0] FUNCT3_OPMVV = 3'b010;
  localparam logic [2:0] FUNCT3_OPIVI = 3'b011;
  localparam logic [2:0] FUNCT3_OPIVX = 3'b100;
  localparam logic [2:0] FUNCT3_OPFVF = 3'b101;
  localparam logic [2:0] FUNCT3_OPMVX = 3'b110;

  localparam logic [5:0] FUNCT6_VADD    = 6'b000000;
  localparam logic [5:0] FUNCT6_VSUB    = 6'b000010;
  localparam logic [5:0] FUNCT6_VAND    = 6'b001001;
  localparam logic [5:0] FUNCT6_VOR     = 6'b001010;
  localparam logic [5:0] FUNCT6_VXOR    = 6'b001011;
  localparam logic [5:0] FUNCT6_VREDSUM = 6'b000000;

endpackage

// File: rtl/vex_marker_pipe.sv
// Fixed-latency head/end marker delay line; advances every cycle regardless of
// lane backpressure and reports when no marker is in flight.
module vex_marker_pipe
  import vex_uop_sequencer_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  input  marker_t push_i,
  output marker_t ex_o,
  output logic    empty_o
);

  marker_t [DEPTH-1:0] stage_q;
  marker_t [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = push_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign ex_o    = stage_q[DEPTH-1];
  assign empty_o = (stage_q == '0);

endmodule

// File: rtl/vex_uop_sequencer.sv
// Splits one vector instruction into VECTOR_LANES-wide uops, drives the lane
// valid/mask under all-lane backpressure and emits EX3 markers plus done.
module vex_uop_sequencer
  import vex_uop_sequencer_pkg::*;
#(
  parameter int VECTOR_LANES = 8,
  parameter int VL_W         = 7,
  parameter int VLMAX        = 64,
  parameter int EX_DEPTH     = 3,
  localparam int UIDX_W      = $clog2(VLMAX / VECTOR_LANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid_i,
  output logic                    instr_ready_o,
  input  logic [5:0]              funct6_i,
  input  logic [2:0]              funct3_i,
  input  logic [VL_W-1:0]         vl_i,
  input  logic                    vm_i,
  input  logic [VLMAX-1:0]        v0_i,
  input  logic                    is_rdc_i,
  input  logic [VECTOR_LANES-1:0] lane_ready_i,
  output logic [VECTOR_LANES-1:0] lane_valid_o,
  output logic [VECTOR_LANES-1:0] lane_mask_o,
  output logic [5:0]              funct6_o,
  output logic [2:0]              funct3_o,
  output logic                    is_rdc_o,
  output logic [VL_W-1:0]         vl_o,
  output logic [UIDX_W-1:0]       uop_idx_o,
  output logic                    head_uop_ex3_o,
  output logic                    end_uop_ex3_o,
  output logic                    done_o,
  output logic                    busy_o
);

  localparam int LANE_W = $clog2(VECTOR_LANES);
  localparam int EIDX_W = $clog2(VLMAX);
  localparam logic [VL_W-1:0] VLMAX_V = VL_W'(VLMAX);

  seq_state_t         state_q,    state_d;
  logic [5:0]         funct6_q,   funct6_d;
  logic [2:0]         funct3_q,   funct3_d;
  logic               is_rdc_q,   is_rdc_d;
  logic               vm_q,       vm_d;
  logic [VLMAX-1:0]   v0_q,       v0_d;
  logic [VL_W-1:0]    vl_q,       vl_d;
  logic [UIDX_W-1:0]  uop_idx_q,  uop_idx_d;
  logic [UIDX_W-1:0]  last_idx_q, last_idx_d;

  logic [VL_W-1:0]         vl_sat;
  logic                    fire;
  logic                    pipe_empty;
  marker_t                 push;
  marker_t                 ex_marker;
  logic [VECTOR_LANES-1:0] lane_valid;
  logic [VECTOR_LANES-1:0] lane_mask;

  assign vl_sat = (vl_i > VLMAX_V) ? VLMAX_V : vl_i;
  assign fire   = (state_q == ST_ISSUE) && (&lane_ready_i);

  // Element index is {uop_idx, lane}; lane outputs depend only on state, so
  // they hold still by construction while the lanes stall.
  genvar gi;
  for (gi = 0; gi < VECTOR_LANES; gi++) begin : g_lane
    logic [EIDX_W-1:0] elem;
    assign elem           = {uop_idx_q, LANE_W'(gi)};
    assign lane_valid[gi] = (state_q == ST_ISSUE) &&
                            ((VL_W+1)'(elem) < (VL_W+1)'(vl_q));
    assign lane_mask[gi]  = lane_valid[gi] && (vm_q || v0_q[elem]);
  end

  always_comb begin
    state_d    = state_q;
    funct6_d   = funct6_q;
    funct3_d   = funct3_q;
    is_rdc_d   = is_rdc_q;
    vm_d       = vm_q;
    v0_d       = v0_q;
    vl_d       = vl_q;
    uop_idx_d  = uop_idx_q;
    last_idx_d = last_idx_q;
    push       = '0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid_i) begin
          funct6_d   = funct6_i;
          funct3_d   = funct3_i;
          is_rdc_d   = is_rdc_i;
          vm_d       = vm_i;
          v0_d       = v0_i;
          vl_d       = vl_sat;
          uop_idx_d  = '0;
          // last uop index = ceil(vl/lanes)-1; meaningless for vl==0, never used then
          last_idx_d = UIDX_W'((vl_sat - VL_W'(1)) >> LANE_W);
          state_d    = (vl_sat == '0) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (fire) begin
          push.head = (uop_idx_q == '0);
          push.last = (uop_idx_q == last_idx_q);
          uop_idx_d = uop_idx_q + UIDX_W'(1);
          if (uop_idx_q == last_idx_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      funct6_q   <= '0;
      funct3_q   <= '0;
      is_rdc_q   <= 1'b0;
      vm_q       <= 1'b0;
      v0_q       <= '0;
      vl_q       <= '0;
      uop_idx_q  <= '0;
      last_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      funct6_q   <= funct6_d;
      funct3_q   <= funct3_d;
      is_rdc_q   <= is_rdc_d;
      vm_q       <= vm_d;
      v0_q       <= v0_d;
      vl_q       <= vl_d;
      uop_idx_q  <= uop_idx_d;
      last_idx_q <= last_idx_d;
    end
  end

  vex_marker_pipe #(
    .DEPTH (EX_DEPTH)
  ) u_marker_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .ex_o    (ex_marker),
    .empty_o (pipe_empty)
  );

  assign instr_ready_o  = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign lane_valid_o   = lane_valid;
  assign lane_mask_o    = lane_mask;
  assign funct6_o       = funct6_q;
  assign funct3_o       = funct3_q;
  assign is_rdc_o       = is_rdc_q;
  assign vl_o           = vl_q;
  assign uop_idx_o      = uop_idx_q;
  assign head_uop_ex3_o = ex_marker.head;
  assign end_uop_ex3_o  = ex_marker.last;
  // Drain ends once the end marker has left the pipe, i.e. the cycle after EX3
  assign done_o         = (state_q == ST_DRAIN) && pipe_empty;

endmodule

// File: tb/tb_vex_uop_sequencer.sv
// Randomized bench for vex_uop_sequencer: directed test-plan instructions then
// random ones, each cycle compared against a transaction-level timing model.
module tb_vex_uop_sequencer;

  localparam int L       = 8;
  localparam int VL_W    = 7;
  localparam int VLMAX   = 64;
  localparam int D       = 3;
  localparam int N_INSTR = 48;
  localparam int LIMIT   = 20000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           instr_valid_i = 1'b0;
  logic           instr_ready_o;
  logic [5:0]     funct6_i = '0;
  logic [2:0]     funct3_i = '0;
  logic [VL_W-1:0] vl_i = '0;
  logic           vm_i = 1'b0;
  logic [VLMAX-1:0] v0_i = '0;
  logic           is_rdc_i = 1'b0;
  logic [L-1:0]   lane_ready_i = '0;
  logic [L-1:0]   lane_valid_o;
  logic [L-1:0]   lane_mask_o;
  logic [5:0]     funct6_o;
  logic [2:0]     funct3_o;
  logic           is_rdc_o;
  logic [VL_W-1:0] vl_o;
  logic [2:0]     uop_idx_o;
  logic           head_uop_ex3_o;
  logic           end_uop_ex3_o;
  logic           done_o;
  logic           busy_o;

  always #5 clk = ~clk;

  vex_uop_sequencer #(
    .VECTOR_LANES (L),
    .VL_W         (VL_W),
    .VLMAX        (VLMAX),
    .EX_DEPTH     (D)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid_i  (instr_valid_i),
    .instr_ready_o  (instr_ready_o),
    .funct6_i       (funct6_i),
    .funct3_i       (funct3_i),
    .vl_i           (vl_i),
    .vm_i           (vm_i),
    .v0_i           (v0_i),
    .is_rdc_i       (is_rdc_i),
    .lane_ready_i   (lane_ready_i),
    .lane_valid_o   (lane_valid_o),
    .lane_mask_o    (lane_mask_o),
    .funct6_o       (funct6_o),
    .funct3_o       (funct3_o),
    .is_rdc_o       (is_rdc_o),
    .vl_o           (vl_o),
    .uop_idx_o      (uop_idx_o),
    .head_uop_ex3_o (head_uop_ex3_o),
    .end_uop_ex3_o  (end_uop_ex3_o),
    .done_o         (done_o),
    .busy_o         (busy_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Pending (offered) instruction
  int          p_vl, p_mode;
  logic        p_vm, p_rdc;
  logic [63:0] p_v0;
  logic [5:0]  p_f6;
  logic [2:0]  p_f3;

  // Model of the accepted instruction
  bit          m_busy = 1'b0;
  int          m_vl, m_nu, m_j, m_mode, m_stall;
  logic        m_vm, m_rdc;
  logic [63:0] m_v0;
  logic [5:0]  m_f6;
  logic [2:0]  m_f3;
  int          head_cyc = -1, end_cyc = -1, done_cyc = -1;
  int          n_acc = 0;
  bit          rst_done = 1'b0;

  // modes: 0 always ready, 1 random stalls, 2 lane 3 stalls 4 cycles in uop 1,
  // 3 reset during uop 2
  task automatic load_instr(input int n);
    p_f6 = 6'($urandom); p_f3 = 3'($urandom); p_rdc = 1'($urandom);
    p_vm = 1'b1; p_v0 = {$urandom, $urandom}; p_mode = 0;
    case (n)
      0: p_vl = 20;
      1: p_vl = 8;
      2: begin p_vl = 16; p_vm = 1'b0; p_v0 = 64'h0000_00A5_0000_3C0F; end
      3: begin p_vl = 24; p_mode = 2; end
      4: p_vl = 0;
      5: p_vl = 100;
      6: begin p_vl = 64; p_mode = 3; end
      default: begin
        p_vl   = $urandom_range(0, 127);
        p_vm   = 1'($urandom);
        p_mode = $urandom_range(0, 1);
      end
    endcase
  endtask

  task automatic model_update();
    if (!m_busy && instr_valid_i) begin
      m_busy = 1'b1;
      m_vl = (p_vl > VLMAX) ? VLMAX : p_vl;
      m_nu = (m_vl + L - 1) / L;
      m_j = 0; m_stall = 0; m_mode = p_mode;
      m_vm = p_vm; m_v0 = p_v0; m_f6 = p_f6; m_f3 = p_f3; m_rdc = p_rdc;
      head_cyc = -1; end_cyc = -1;
      done_cyc = (m_vl == 0) ? cyc + 1 : -1;
      n_acc++;
      if (n_acc < N_INSTR) load_instr(n_acc);
    end else if (m_busy) begin
      if (m_j < m_nu && lane_ready_i == '1) begin
        if (m_j == 0) head_cyc = cyc + D;
        if (m_j == m_nu - 1) begin
          end_cyc  = cyc + D;
          done_cyc = cyc + D + 1;
        end
        m_j++;
      end
      if (cyc == done_cyc) m_busy = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [L-1:0] ev, em;
    ev = '0; em = '0;
    chk("instr_ready", 64'(instr_ready_o), 64'(!m_busy));
    chk("busy", 64'(busy_o), 64'(m_busy));
    if (m_busy && m_j < m_nu) begin
      for (int k = 0; k < L; k++) begin
        int e;
        e = m_j * L + k;
        if (e < m_vl) begin
          ev[k] = 1'b1;
          em[k] = m_vm | m_v0[e];
        end
      end
      chk("uop_idx", 64'(uop_idx_o), 64'(m_j));
    end
    chk("lane_valid", 64'(lane_valid_o), 64'(ev));
    chk("lane_mask", 64'(lane_mask_o), 64'(em));
    chk("head_ex3", 64'(head_uop_ex3_o), 64'(cyc == head_cyc));
    chk("end_ex3", 64'(end_uop_ex3_o), 64'(cyc == end_cyc));
    chk("done", 64'(done_o), 64'(cyc == done_cyc));
    if (m_busy) begin
      chk("vl_o", 64'(vl_o), 64'(m_vl));
      chk("funct6_o", 64'(funct6_o), 64'(m_f6));
      chk("funct3_o", 64'(funct3_o), 64'(m_f3));
      chk("is_rdc_o", 64'(is_rdc_o), 64'(m_rdc));
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, 64'(instr_ready_o), 64'd1);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_valid"}, 64'(lane_valid_o), 64'd0);
    chk({tag, "_mask"}, 64'(lane_mask_o), 64'd0);
    chk({tag, "_markers"}, 64'({head_uop_ex3_o, end_uop_ex3_o, done_o}), 64'd0);
    chk({tag, "_fields"}, 64'({funct6_o, funct3_o, is_rdc_o, vl_o, uop_idx_o}), 64'd0);
  endtask

  task automatic drive_inputs();
    instr_valid_i = (n_acc < N_INSTR);
    funct6_i = p_f6; funct3_i = p_f3; is_rdc_i = p_rdc;
    vl_i = VL_W'(p_vl); vm_i = p_vm; v0_i = p_v0;
    if (m_busy && m_mode == 1 && $urandom_range(0, 3) == 0) begin
      lane_ready_i = L'($urandom);
    end else if (m_busy && m_mode == 2 && m_j == 1 && m_stall < 4) begin
      lane_ready_i = 8'hF7;
      m_stall++;
    end else begin
      lane_ready_i = '1;
    end
  endtask

  initial begin
    load_instr(0);
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    check_outputs();
    while ((n_acc < N_INSTR || m_busy) && cyc < LIMIT) begin
      if (m_busy && m_mode == 3 && m_j == 2 && !rst_done) begin
        rst_done = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_state("abort");
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        m_busy = 1'b0; head_cyc = -1; end_cyc = -1; done_cyc = -1;
        check_outputs();
      end
      drive_inputs();
      @(posedge clk);
      model_update();
      cyc++;
      @(negedge clk);
      check_outputs();
    end
    if (cyc >= LIMIT) chk("timeout", 64'(cyc), 64'(LIMIT - 1));
    chk("all_accepted", 64'(n_acc), 64'(N_INSTR));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
